// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers K operand rows, then streams them diagonally skewed into the PE array with a zero-filled drain (skew enabled by FEEDER_SKEW_EN).
module systolic_feeder #(
  parameter int DATAWIDTH = 16,
  parameter int ARRAY_SIZE = 2,
  parameter int DEPTH = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ARRAY_SIZE*DATAWIDTH-1:0] data_row_in,
  input  logic [ARRAY_SIZE*DATAWIDTH-1:0] weight_row_in,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0] data_out,
  output logic [ARRAY_SIZE*DATAWIDTH-1:0] weight_out,
  output logic                            systolic_en,
  output logic                            busy,
  output logic                            done
);
  localparam int N = ARRAY_SIZE;
  localparam int K = DEPTH;
  localparam int W = DATAWIDTH;
`ifdef FEEDER_SKEW_EN
  localparam int L = K + N - 1;
  localparam bit SKEW = 1'b1;
`else
  localparam int L = K;
  localparam bit SKEW = 1'b0;
`endif
  localparam int T = L + DRAIN_CYCLES;
  localparam int CW = $clog2(T + 2);
  localparam int PW = $clog2(K) + 1;
  localparam int AW = K > 1 ? $clog2(K) : 1;

  typedef enum logic [1:0] {LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [N*W-1:0] dbuf [K];
  logic [N*W-1:0] wbuf [K];
  logic [N*W-1:0] d_nx, w_nx;
  logic accept, run, en_nx;

  assign in_ready = state == LOAD || state == DONE;
  assign accept = in_valid && in_ready;
  assign run = state == STREAM || state == DRAIN;
  // cnt 0 is a setup cycle; beat t is registered while cnt == t, so en stops once cnt reaches T
  assign en_nx = run && cnt != CW'(T);

  always_comb begin
    state_nx = in_ready ? (accept && wr_ptr == PW'(K - 1) ? STREAM : LOAD)
             : state == STREAM ? (cnt == CW'(L) ? (DRAIN_CYCLES > 0 ? DRAIN : DONE) : STREAM)
             : (cnt == CW'(T) ? DONE : DRAIN);
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam logic [CW:0] OFF = SKEW ? (CW+1)'(i) : '0;
    logic [CW:0] j;
    logic hit;
    assign j = {1'b0, cnt} - OFF;
    assign hit = en_nx && {1'b0, cnt} >= OFF && j < (CW+1)'(K);
    assign d_nx[i*W +: W] = hit ? dbuf[j[AW-1:0]][i*W +: W] : '0;
    assign w_nx[i*W +: W] = hit ? wbuf[j[AW-1:0]][i*W +: W] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      wr_ptr <= '0;
      cnt <= '0;
      data_out <= '0;
      weight_out <= '0;
      systolic_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= accept ? (wr_ptr == PW'(K - 1) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
      cnt <= run ? cnt + CW'(1) : '0;
      data_out <= d_nx;
      weight_out <= w_nx;
      systolic_en <= en_nx;
      busy <= en_nx;
      done <= state_nx == DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      dbuf[wr_ptr[AW-1:0]] <= data_row_in;
      wbuf[wr_ptr[AW-1:0]] <= weight_row_in;
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random and directed stimulus checked against a timeline model of the feeder, plus literal tile expectations.
module tb_systolic_feeder;
  localparam int W = 16;
  localparam int N = 2;
  localparam int K = 4;
  localparam int D = 2;
`ifdef FEEDER_SKEW_EN
  localparam int L = K + N - 1;
  localparam bit SK = 1'b1;
  localparam int LIT = 7;
`else
  localparam int L = K;
  localparam bit SK = 1'b0;
  localparam int LIT = 6;
`endif
  localparam int T = L + D;

  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [N*W-1:0] drow = '0, wrow = '0, data_out, weight_out;
  logic systolic_en, busy, done;
  logic v2 = 0, rdy2, en2, busy2, done2;
  logic [W-1:0] d2in = '0, w2in = '0, d2, w2;

  always #5 clk = ~clk;

  systolic_feeder #(.DATAWIDTH(W), .ARRAY_SIZE(N), .DEPTH(K), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_row_in(drow), .weight_row_in(wrow), .data_out(data_out), .weight_out(weight_out),
    .systolic_en(systolic_en), .busy(busy), .done(done));

  systolic_feeder #(.DATAWIDTH(W), .ARRAY_SIZE(1), .DEPTH(1), .DRAIN_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
    .data_row_in(d2in), .weight_row_in(w2in), .data_out(d2), .weight_out(w2),
    .systolic_en(en2), .busy(busy2), .done(done2));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: after the K-th row is taken, cycle n (counted from that edge) shows beat n-1 for n in 1..T, then done at n=T+1
  logic [W-1:0] ld_d [K][N], ld_w [K][N], td [K][N], tw [K][N];
  bit strm = 0, started = 0, rdy_pre;
  int n = 0, nrows = 0, j;
  logic [N*W-1:0] e_d, e_w;
  logic e_en, e_done, e_rdy;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      strm = 0;
      n = 0;
      nrows = 0;
    end else begin
      rdy_pre = !strm || n == T + 1;
      if (strm) begin
        n++;
        if (n > T + 1) strm = 0;
      end
      if (in_valid && rdy_pre) begin
        for (int i = 0; i < N; i++) begin
          ld_d[nrows][i] = drow[i*W +: W];
          ld_w[nrows][i] = wrow[i*W +: W];
        end
        nrows++;
        if (nrows == K) begin
          td = ld_d;
          tw = ld_w;
          strm = 1;
          n = 0;
          nrows = 0;
        end
      end
    end
    e_en = strm && n >= 1 && n <= T;
    e_done = strm && n == T + 1;
    e_rdy = !strm || e_done;
    for (int i = 0; i < N; i++) begin
      j = n - 1 - (SK ? i : 0);
      e_d[i*W +: W] = (e_en && j >= 0 && j < K) ? td[j][i] : '0;
      e_w[i*W +: W] = (e_en && j >= 0 && j < K) ? tw[j][i] : '0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("data_out", data_out, e_d);
      chk("weight_out", weight_out, e_w);
      chk("systolic_en", systolic_en, e_en);
      chk("busy", busy, e_en);
      chk("done", done, e_done);
      chk("in_ready", in_ready, e_rdy);
    end
  end

  logic [31:0] cd [$], cw [$];
  logic [31:0] ed [7], ew [7];
  int nd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input int r);
    drow = {16'(r + 11), 16'(r + 1)};
    wrow = {16'(r + 31), 16'(r + 21)};
  endtask

  task automatic load_tile();
    for (int r = 0; r < K; r++) begin
      set_row(r);
      in_valid = 1;
      step();
    end
    in_valid = 0;
  endtask

  task automatic capture(input int cyc);
    cd.delete();
    cw.delete();
    nd = 0;
    repeat (cyc) begin
      @(negedge clk);
      if (systolic_en) begin
        cd.push_back(data_out);
        cw.push_back(weight_out);
      end
      if (done) nd++;
    end
  endtask

  task automatic check_lit();
    chk("tile_en_len", cd.size(), LIT);
    for (int k = 0; k < LIT; k++) begin
      chk("tile_data", k < cd.size() ? cd[k] : 32'hDEAD, ed[k]);
      chk("tile_weight", k < cw.size() ? cw[k] : 32'hDEAD, ew[k]);
    end
    chk("tile_done_cnt", nd, 1);
  endtask

  initial begin
`ifdef FEEDER_SKEW_EN
    ed = '{32'h0000_0001, 32'h000B_0002, 32'h000C_0003, 32'h000D_0004, 32'h000E_0000, 32'h0, 32'h0};
    ew = '{32'h0000_0015, 32'h001F_0016, 32'h0020_0017, 32'h0021_0018, 32'h0022_0000, 32'h0, 32'h0};
`else
    ed = '{32'h000B_0001, 32'h000C_0002, 32'h000D_0003, 32'h000E_0004, 32'h0, 32'h0, 32'h0};
    ew = '{32'h001F_0015, 32'h0020_0016, 32'h0021_0017, 32'h0022_0018, 32'h0, 32'h0, 32'h0};
`endif
    step();
    step();
    rst = 0;
    load_tile();
    capture(12);
    check_lit();
    for (int c = 0; c < 2 * K; c++) begin
      in_valid = c % 2 == 0;
      set_row(c / 2);
      step();
    end
    in_valid = 0;
    capture(12);
    check_lit();
    for (int r = 0; r < K; r++) begin
      set_row(r);
      in_valid = 1;
      step();
    end
    drow = '1;
    wrow = '1;
    repeat (T + 2 + K - 1) step();
    in_valid = 0;
    repeat (T + 4) step();
    load_tile();
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_en", systolic_en, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_data", data_out, 0);
    load_tile();
    capture(12);
    check_lit();
    repeat (400) begin
      in_valid = $urandom_range(0, 2) != 0;
      drow = $urandom;
      wrow = $urandom;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;
    in_valid = 0;
    repeat (T + 4) step();
    rst = 1;
    step();
    rst = 0;
    v2 = 1;
    d2in = 16'h0007;
    w2in = 16'h0003;
    step();
    v2 = 0;
    @(negedge clk);
    chk("deg_setup_en", en2, 0);
    chk("deg_setup_ready", rdy2, 0);
    @(negedge clk);
    chk("deg_beat_en", en2, 1);
    chk("deg_beat_busy", busy2, 1);
    chk("deg_beat_data", d2, 16'h0007);
    chk("deg_beat_weight", w2, 16'h0003);
    chk("deg_beat_done", done2, 0);
    @(negedge clk);
    chk("deg_done", done2, 1);
    chk("deg_done_en", en2, 0);
    chk("deg_done_ready", rdy2, 1);
    chk("deg_done_data", d2, 0);
    @(negedge clk);
    chk("deg_after_done", done2, 0);
    chk("deg_after_ready", rdy2, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
